// File: rtl/clock_enables.sv
// Clock-enable generator and reset sequencer for the 32 MHz system clock.
// Produces one-clock-wide enable strobes for the CPU (two phases), the pixel
// pipeline and the 1 MHz slow logic, and holds the system in reset until the
// PLL has been continuously locked for RST_CYCLES clocks.
module clock_enables #(
  parameter int CPU_DIV    = 8,
  parameter int TURBO_DIV  = 4,
  parameter int PIX_DIV    = 4,
  parameter int SLOW_DIV   = 32,
  parameter int RST_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  input  logic turbo,
  input  logic pause,
  output logic ce_cpu_p,
  output logic ce_cpu_n,
  output logic ce_pix,
  output logic ce_slow,
  output logic rst_out_n
);

  // CPU counter is wide enough for whichever of the two periods is longer.
  localparam int CPU_MAX = (CPU_DIV > TURBO_DIV) ? CPU_DIV : TURBO_DIV;
  localparam int CPU_W   = (CPU_MAX > 1) ? $clog2(CPU_MAX) : 1;
  localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CPU_W-1:0] CPU_LAST_N = CPU_W'(CPU_DIV - 1);
  localparam logic [CPU_W-1:0] CPU_LAST_T = CPU_W'(TURBO_DIV - 1);
  localparam logic [CPU_W-1:0] CPU_HALF_N = CPU_W'(CPU_DIV / 2);
  localparam logic [CPU_W-1:0] CPU_HALF_T = CPU_W'(TURBO_DIV / 2);
  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_COUNT = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state_q;
  logic               sync1_q;
  logic               sync2_q;
  logic               locked_s;
  logic [RST_W-1:0]   rst_cnt_q;
  logic               rst_out_n_q;
  logic               div_run;

  logic [CPU_W-1:0]   cnt_cpu_q;
  logic [CPU_W-1:0]   cnt_cpu_d;
  logic [CPU_W-1:0]   cpu_last;
  logic [CPU_W-1:0]   cpu_half;
  logic               cpu_wrap;
  logic               turbo_l_q;
  logic               pause_l_q;
  logic               ce_cpu_p_q;
  logic               ce_cpu_n_q;

  // Two-flop synchroniser bringing the PLL lock into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // Reset sequencer: wait for lock, count RST_CYCLES locked clocks, then run;
  // any loss of lock sends it straight back to the start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HOLD;
      rst_cnt_q   <= '0;
      rst_out_n_q <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          rst_cnt_q   <= '0;
          rst_out_n_q <= 1'b0;
          if (locked_s) begin
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!locked_s) begin
            state_q   <= S_HOLD;
            rst_cnt_q <= '0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_q     <= S_RUN;
            rst_out_n_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_q     <= S_HOLD;
            rst_cnt_q   <= '0;
            rst_out_n_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_HOLD;
          rst_cnt_q   <= '0;
          rst_out_n_q <= 1'b0;
        end
      endcase
    end
  end

  // Dividers advance only on edges that keep the FSM out of S_HOLD, so the
  // counters sit at 0 (and every enable is 0) for the whole time in S_HOLD.
  assign div_run = (state_q != S_HOLD) && locked_s;

  // CPU period length and half-point follow the turbo selection latched at the last wrap.
  always_comb begin
    cpu_last  = turbo_l_q ? CPU_LAST_T : CPU_LAST_N;
    cpu_half  = turbo_l_q ? CPU_HALF_T : CPU_HALF_N;
    cpu_wrap  = (cnt_cpu_q == cpu_last);
    cnt_cpu_d = '0;
    if (div_run && !cpu_wrap) begin
      cnt_cpu_d = cnt_cpu_q + CPU_W'(1);
    end
  end

  // CPU divider: turbo/pause are sampled only at the wrap so periods are never cut.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_cpu_q  <= '0;
      turbo_l_q  <= 1'b0;
      pause_l_q  <= 1'b0;
      ce_cpu_p_q <= 1'b0;
      ce_cpu_n_q <= 1'b0;
    end else begin
      cnt_cpu_q  <= cnt_cpu_d;
      if (div_run && cpu_wrap) begin
        turbo_l_q <= turbo;
        pause_l_q <= pause;
      end
      ce_cpu_p_q <= div_run && !pause_l_q && (cnt_cpu_q == '0);
      ce_cpu_n_q <= div_run && !pause_l_q && (cnt_cpu_q == cpu_half);
    end
  end

  // Pixel (gi=0) and slow (gi=1) dividers share one free-running scheme.
  for (genvar gi = 0; gi < 2; gi++) begin : g_simple
    localparam int DIV = (gi == 0) ? PIX_DIV : SLOW_DIV;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         ce_q;

    // Wrap at LAST; cleared whenever the dividers are stopped.
    always_comb begin
      cnt_d = '0;
      if (div_run && (cnt_q != LAST)) begin
        cnt_d = cnt_q + W'(1);
      end
    end

    // Strobe in the cycle after the counter sits at 0.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ce_q  <= div_run && (cnt_q == '0);
      end
    end

    if (gi == 0) begin : g_pix
      assign ce_pix = ce_q;
    end else begin : g_slow
      assign ce_slow = ce_q;
    end
  end

  assign ce_cpu_p  = ce_cpu_p_q;
  assign ce_cpu_n  = ce_cpu_n_q;
  assign rst_out_n = rst_out_n_q;

endmodule

// File: tb/tb_clock_enables.sv
// Bench for clock_enables: randomised and directed stimulus, a period-level
// reference model feeding a scoreboard queue, and a negedge monitor that
// compares every cycle's outputs against the queued expectation.
module tb_clock_enables;

  localparam int CPU_DIV    = 8;
  localparam int TURBO_DIV  = 4;
  localparam int PIX_DIV    = 4;
  localparam int SLOW_DIV   = 32;
  localparam int RST_CYCLES = 16;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic locked = 1'b0;
  logic turbo  = 1'b0;
  logic pause  = 1'b0;
  logic ce_cpu_p;
  logic ce_cpu_n;
  logic ce_pix;
  logic ce_slow;
  logic rst_out_n;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // expected {ce_cpu_p, ce_cpu_n, ce_pix, ce_slow, rst_out_n}
  logic [4:0] exp_q[$];
  int         cyc_q[$];

  // reference model state
  logic lk_dly[$];
  int   streak;
  bit   sel_turbo;
  bit   sel_pause;
  int   per_start;
  int   per_len;
  bit   per_pause;

  clock_enables #(
    .CPU_DIV   (CPU_DIV),
    .TURBO_DIV (TURBO_DIV),
    .PIX_DIV   (PIX_DIV),
    .SLOW_DIV  (SLOW_DIV),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .turbo    (turbo),
    .pause    (pause),
    .ce_cpu_p (ce_cpu_p),
    .ce_cpu_n (ce_cpu_n),
    .ce_pix   (ce_pix),
    .ce_slow  (ce_slow),
    .rst_out_n(rst_out_n)
  );

  always #5 clock = ~clock;

  function automatic void model_clear();
    lk_dly.delete();
    lk_dly.push_back(1'b0);
    lk_dly.push_back(1'b0);
    streak    = 0;
    sel_turbo = 1'b0;
    sel_pause = 1'b0;
    per_start = 0;
    per_len   = CPU_DIV;
    per_pause = 1'b0;
  endfunction

  // One clock edge of the reference: lock seen two edges late, a streak of
  // locked edges decides reset release, dividers count from the second
  // locked edge, CPU work is tracked as whole periods.
  function automatic void model_edge();
    logic [4:0] e;
    logic       ls;
    int         pos;
    int         off;
    e = '0;
    cycle++;
    if (!reset) begin
      model_clear();
    end else begin
      ls = lk_dly.pop_front();
      lk_dly.push_back(locked);
      streak = ls ? streak + 1 : 0;
      if (streak >= 2) begin
        pos = streak - 2;
        if (pos == 0) begin
          per_start = 0;
          per_len   = sel_turbo ? TURBO_DIV : CPU_DIV;
          per_pause = sel_pause;
        end
        off  = pos - per_start;
        e[4] = (off == 0) && !per_pause;
        e[3] = (off == per_len / 2) && !per_pause;
        e[2] = (pos % PIX_DIV) == 0;
        e[1] = (pos % SLOW_DIV) == 0;
        if (off == per_len - 1) begin
          sel_turbo = turbo;
          sel_pause = pause;
          per_start = pos + 1;
          per_len   = sel_turbo ? TURBO_DIV : CPU_DIV;
          per_pause = sel_pause;
        end
      end
      e[0] = streak > RST_CYCLES;
    end
    exp_q.push_back(e);
    cyc_q.push_back(cycle);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      #1;
    end
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic async_reset();
    logic [4:0] got;
    #6;
    reset = 1'b0;
    model_clear();
    #1;
    got = {ce_cpu_p, ce_cpu_n, ce_pix, ce_slow, rst_out_n};
    vectors++;
    if (got !== 5'b0) begin
      miscompares++;
      $display("FAIL async_reset outputs got %b expected 00000", got);
    end
  endtask

  // Scoreboard monitor.
  initial begin : monitor
    logic [4:0] e;
    logic [4:0] got;
    int         c;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        c   = cyc_q.pop_front();
        got = {ce_cpu_p, ce_cpu_n, ce_pix, ce_slow, rst_out_n};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle %0d outputs p,n,pix,slow,rst got %b expected %b", c, got, e);
        end
      end
    end
  end

  a_wide_p: assert property (@(posedge clock) disable iff (!reset) ce_cpu_p |=> !ce_cpu_p)
    else begin miscompares++; $display("FAIL wide_ce_cpu_p cycle %0d", cycle); end
  a_wide_n: assert property (@(posedge clock) disable iff (!reset) ce_cpu_n |=> !ce_cpu_n)
    else begin miscompares++; $display("FAIL wide_ce_cpu_n cycle %0d", cycle); end
  a_wide_pix: assert property (@(posedge clock) disable iff (!reset) ce_pix |=> !ce_pix)
    else begin miscompares++; $display("FAIL wide_ce_pix cycle %0d", cycle); end
  a_wide_slow: assert property (@(posedge clock) disable iff (!reset) ce_slow |=> !ce_slow)
    else begin miscompares++; $display("FAIL wide_ce_slow cycle %0d", cycle); end
  a_pn_excl: assert property (@(posedge clock) disable iff (!reset) !(ce_cpu_p && ce_cpu_n))
    else begin miscompares++; $display("FAIL pn_overlap cycle %0d", cycle); end

  initial begin : stimulus
    int r;
    model_clear();

    $display("txn reset_hold cycle %0d", cycle);
    step(3);

    $display("txn release_locked cycle %0d", cycle);
    reset  = 1'b1;
    locked = 1'b1;
    step(120);

    $display("txn lock_drop_in_count cycle %0d", cycle);
    async_reset();
    step(2);
    reset = 1'b1;
    step(13);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(60);

    $display("txn lock_drop_in_run cycle %0d", cycle);
    locked = 1'b0;
    step(8);
    locked = 1'b1;
    step(40);

    $display("txn turbo_on_off cycle %0d", cycle);
    step(3);
    turbo = 1'b1;
    step(30);
    turbo = 1'b0;
    step(32);

    $display("txn pause_20 cycle %0d", cycle);
    step(5);
    pause = 1'b1;
    step(20);
    pause = 1'b0;
    step(30);

    $display("txn async_reset_in_run cycle %0d", cycle);
    async_reset();
    step(3);
    reset = 1'b1;
    step(60);

    $display("txn random cycle %0d", cycle);
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (locked && r < 2) locked = 1'b0;
      else if (!locked && r < 60) locked = 1'b1;
      if (r >= 10 && r < 16) turbo = ~turbo;
      if (r >= 20 && r < 25) pause = ~pause;
      if (r == 199) begin
        async_reset();
        step(2);
        reset = 1'b1;
      end
      step(1);
    end

    @(negedge clock);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
